// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the fifo_prefetch family.
package fifo_pkg;

  localparam int unsigned AE_THRESH_DEF = 2;
  localparam int unsigned AF_MARGIN_DEF = 2;

  // Fill level must represent 0..DEPTH+2 (memory + in-flight read + two stage entries).
  function automatic int unsigned fill_width(input int unsigned log2_depth);
    return $clog2((32'd1 << log2_depth) + 32'd2) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Behavioural 1R1W memory, WIDTH x 2**ADDR_W, registered read data (1-cycle latency), no array reset.
module fifo_mem_1r1w #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/fifo_prefetch.sv
// Single-clock FIFO: 1R1W memory plus a two-entry prefetch stage giving registered qout at 1 word/cycle.
// Optional peak_level output enabled by defining FIFO_PEAK_LEVEL_EN.
module fifo_prefetch
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LOG2_OF_DEPTH = 4,
  parameter int unsigned AF_THRESH     = (2 ** LOG2_OF_DEPTH) - AF_MARGIN_DEF,
  parameter int unsigned AE_THRESH     = AE_THRESH_DEF
) (
  input  logic                                 clk,
  input  logic                                 arst_n_in,
  input  logic [WIDTH-1:0]                     din,
  input  logic                                 input_valid,
  output logic                                 input_ready,
  output logic [WIDTH-1:0]                     qout,
  output logic                                 output_valid,
  input  logic                                 output_ready,
  input  logic                                 flush,
  output logic [fill_width(LOG2_OF_DEPTH)-1:0] fill_level,
  output logic                                 almost_full,
  output logic                                 almost_empty
`ifdef FIFO_PEAK_LEVEL_EN
  ,
  output logic [fill_width(LOG2_OF_DEPTH)-1:0] peak_level
`endif
);

  localparam int unsigned DEPTH = 2 ** LOG2_OF_DEPTH;
  localparam int unsigned AW    = LOG2_OF_DEPTH + 1;
  localparam int unsigned FW    = fill_width(LOG2_OF_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_entry_t;

  if ((AF_THRESH > DEPTH + 2) || (AE_THRESH >= AF_THRESH)) begin : g_param_check
    $error("fifo_prefetch: illegal AF_THRESH/AE_THRESH combination");
  end

  logic [AW-1:0]    waddr_q, waddr_d, raddr_q, raddr_d;
  logic [FW-1:0]    fill_q, fill_d;
  stage_entry_t     head_q, head_d, tail_q, tail_d;
  stage_entry_t     land_e, seq0, seq1;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] rdata;
  logic             mem_full, mem_empty, wr_fire, pop, issue;
  logic [1:0]       occ;

  assign mem_empty    = (waddr_q == raddr_q);
  assign mem_full     = ((waddr_q - raddr_q) == AW'(DEPTH));
  assign input_ready  = !mem_full && !flush;
  assign wr_fire      = input_valid && input_ready;
  assign output_valid = head_q.valid || inflight_q;
  assign pop          = output_valid && output_ready;
  // With the stage empty, a word landing this cycle is presented straight from the memory read register.
  assign qout         = (!head_q.valid && inflight_q) ? rdata : head_q.data;
  assign occ          = 2'(head_q.valid) + 2'(tail_q.valid) + 2'(inflight_q);
  assign issue        = !mem_empty && ((occ < 2'd2) || pop);

  assign fill_level   = fill_q;
  assign almost_full  = (fill_q >= FW'(AF_THRESH));
  assign almost_empty = (fill_q <= FW'(AE_THRESH));

  fifo_mem_1r1w #(
    .WIDTH (WIDTH),
    .ADDR_W(LOG2_OF_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_fire),
    .waddr(waddr_q[LOG2_OF_DEPTH-1:0]),
    .wdata(din),
    .re   (issue),
    .raddr(raddr_q[LOG2_OF_DEPTH-1:0]),
    .rdata(rdata)
  );

  // Ordered view of stored words is head, tail, landing word; a pop drops the first.
  always_comb begin
    land_e.valid = inflight_q;
    land_e.data  = rdata;
    seq0         = head_q.valid ? head_q : land_e;
    seq1         = '0;
    if (tail_q.valid)      seq1 = tail_q;
    else if (head_q.valid) seq1 = land_e;
    head_d     = pop ? seq1 : seq0;
    tail_d     = pop ? '0 : seq1;
    waddr_d    = waddr_q + AW'(wr_fire);
    raddr_d    = raddr_q + AW'(issue);
    inflight_d = issue;
    fill_d     = fill_q + FW'(wr_fire) - FW'(pop);
    if (flush) begin
      waddr_d    = '0;
      raddr_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = 1'b0;
      fill_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      waddr_q    <= '0;
      raddr_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      fill_q     <= fill_d;
    end
  end

`ifdef FIFO_PEAK_LEVEL_EN
  logic [FW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = (fill_q > peak_q) ? fill_q : peak_q;
    if (flush) peak_d = '0;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) peak_q <= '0;
    else            peak_q <= peak_d;
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_fifo_prefetch.sv
// Directed self-checking bench for fifo_prefetch (DEPTH=16, WIDTH=8, default thresholds).
module tb_fifo_prefetch;
  import fifo_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LOG2  = 4;
  localparam int unsigned FW    = fill_width(LOG2);

  logic             clk = 1'b0;
  logic             arst_n_in = 1'b0;
  logic [WIDTH-1:0] din;
  logic             input_valid, input_ready;
  logic [WIDTH-1:0] qout;
  logic             output_valid, output_ready, flush;
  logic [FW-1:0]    fill_level;
  logic             almost_full, almost_empty;
`ifdef FIFO_PEAK_LEVEL_EN
  logic [FW-1:0]    peak_level;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          n_acc, n_wr, n_rd, model, cyc;
  logic [7:0]  sb [$];

  fifo_prefetch #(
    .WIDTH(WIDTH),
    .LOG2_OF_DEPTH(LOG2)
  ) dut (
    .clk(clk),
    .arst_n_in(arst_n_in),
    .din(din),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .qout(qout),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .flush(flush),
    .fill_level(fill_level),
    .almost_full(almost_full),
    .almost_empty(almost_empty)
`ifdef FIFO_PEAK_LEVEL_EN
    ,
    .peak_level(peak_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    din = '0; input_valid = 1'b0; output_ready = 1'b0; flush = 1'b0;
    #12;
    check("rst_ov", output_valid, 0);
    check("rst_qout", qout, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_ir", input_ready, 1);
    check("rst_fill", fill_level, 0);
    @(posedge clk); #1; arst_n_in = 1'b1;

    // single word latency
    din = 8'h11; input_valid = 1'b1; output_ready = 1'b1;
    @(negedge clk); check("t1_ov_c0", output_valid, 0);
    tick(); input_valid = 1'b0; din = '0;
    @(negedge clk); check("t1_fill_c1", fill_level, 1); check("t1_ov_c1", output_valid, 0);
    tick();
    @(negedge clk); check("t1_ov_c2", output_valid, 1); check("t1_qout_c2", qout, 8'h11);
    tick();
    @(negedge clk); check("t1_fill_c3", fill_level, 0); check("t1_ov_c3", output_valid, 0);
    tick(); output_ready = 1'b0;

    // fill to capacity, then drain
    n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      din = 8'(n_acc); input_valid = 1'b1;
      @(negedge clk);
      if (input_ready) n_acc++;
      tick();
    end
    input_valid = 1'b0;
    @(negedge clk);
    check("t2_accepted", n_acc, 18);
    check("t2_ir", input_ready, 0);
    check("t2_fill", fill_level, 18);
    check("t2_af", almost_full, 1);
    check("t2_ae", almost_empty, 0);
    check("t2_ov", output_valid, 1);
    check("t2_head", qout, 0);
    tick(); output_ready = 1'b1;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      check("t2d_ov", output_valid, 1);
      check("t2d_qout", qout, j);
      check("t2d_fill", fill_level, 18 - j);
      check("t2d_ae", almost_empty, (18 - j) <= 2);
      check("t2d_af", almost_full, (18 - j) >= 14);
      tick();
    end
    @(negedge clk);
    check("t2e_ov", output_valid, 0); check("t2e_fill", fill_level, 0);
    check("t2e_ae", almost_empty, 1); check("t2e_ir", input_ready, 1);
    tick(); output_ready = 1'b0;

    // continuous streaming
    output_ready = 1'b1;
    for (int c = 0; c < 103; c++) begin
      input_valid = (c < 100); din = 8'(c);
      @(negedge clk);
      check("t3_ir", input_ready, 1);
      if (c >= 2 && c <= 101) begin
        check("t3_ov", output_valid, 1);
        check("t3_qout", qout, 8'(c - 2));
      end
      if (c >= 2 && c <= 100) check("t3_fill", fill_level, 2);
      if (c == 102) begin
        check("t3_end_ov", output_valid, 0);
        check("t3_end_fill", fill_level, 0);
      end
      tick();
    end
    input_valid = 1'b0; output_ready = 1'b0;

    // random handshakes against a scoreboard
    n_wr = 0; n_rd = 0; model = 0; cyc = 0;
    while (n_rd < 1000 && cyc < 20000) begin
      input_valid  = (n_wr < 1000) && ($urandom_range(0, 1) == 1);
      din          = 8'($urandom);
      output_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check("t4_fill", fill_level, model);
      if (input_valid && input_ready) begin
        sb.push_back(din); n_wr++; model++;
      end
      if (output_valid && output_ready) begin
        if (sb.size() == 0) check("t4_underflow", output_valid, 0);
        else begin
          check("t4_data", qout, sb.pop_front());
          n_rd++; model--;
        end
      end
      tick(); cyc++;
    end
    check("t4_done", n_rd, 1000);
    input_valid = 1'b0; output_ready = 1'b0;
    tick();

    // flush with a concurrent write
    @(negedge clk); check("t5_fill0", fill_level, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      input_valid = 1'b1; din = 8'(i + 1); tick();
    end
    flush = 1'b1; input_valid = 1'b1; din = 8'hAA;
    @(negedge clk);
    check("t5_fill10", fill_level, 10); check("t5_ov_pre", output_valid, 1);
    check("t5_ir_flush", input_ready, 0);
    tick(); flush = 1'b0; input_valid = 1'b0;
    @(negedge clk);
    check("t5_fill_post", fill_level, 0); check("t5_ov_post", output_valid, 0);
    tick(); output_ready = 1'b1; din = 8'h5A; input_valid = 1'b1;
    tick(); input_valid = 1'b0;
    @(negedge clk); check("t5_ov_w1", output_valid, 0); check("t5_fill_w1", fill_level, 1);
    tick();
    @(negedge clk); check("t5_ov_w2", output_valid, 1); check("t5_qout_w2", qout, 8'h5A);
    tick();
    @(negedge clk); check("t5_ov_w3", output_valid, 0); check("t5_fill_w3", fill_level, 0);
    tick(); output_ready = 1'b0;

`ifdef FIFO_PEAK_LEVEL_EN
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk); check("t6_peak_clr", peak_level, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      input_valid = 1'b1; din = 8'(i); tick();
    end
    input_valid = 1'b0; output_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    output_ready = 1'b0;
    @(negedge clk); check("t6_fill3", fill_level, 3); check("t6_peak12", peak_level, 12);
    tick(); flush = 1'b1;
    @(negedge clk); check("t6_peak_hold", peak_level, 12);
    tick(); flush = 1'b0;
    @(negedge clk); check("t6_peak_flush", peak_level, 0); check("t6_fill_flush", fill_level, 0);
    tick();
`endif

    // asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      input_valid = 1'b1; din = 8'hC0 + 8'(i); tick();
    end
    input_valid = 1'b0;
    #2; arst_n_in = 1'b0; #1;
    check("t7_ov", output_valid, 0); check("t7_fill", fill_level, 0);
    check("t7_qout", qout, 0); check("t7_ae", almost_empty, 1);
    check("t7_af", almost_full, 0); check("t7_ir", input_ready, 1);
    @(posedge clk); #1; arst_n_in = 1'b1;
    din = 8'h3C; input_valid = 1'b1; output_ready = 1'b1;
    @(negedge clk); check("t7_ov_c0", output_valid, 0);
    tick(); input_valid = 1'b0;
    @(negedge clk); check("t7_ov_c1", output_valid, 0); check("t7_fill_c1", fill_level, 1);
    tick();
    @(negedge clk); check("t7_ov_c2", output_valid, 1); check("t7_qout_c2", qout, 8'h3C);
    tick();
    @(negedge clk); check("t7_ov_c3", output_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
